spi_flash_writer: RTL and testbench
===================================

// Module: spi_flash_writer
// PURPOSE
//   SPI NOR flash program/erase engine; write-side companion of the Fast Read engine on the same mspi_* pins.
//   One request per transaction: a single-byte Page Program (0x02) or a 4 KiB Sector Erase (0x20).
//   Each request runs WREN (0x06), then the command, then polls RDSR (0x05) until WIP=0.
//   Top level muxes cs/mosi/sclk between reader and writer. Only one engine is busy at a time.
// PARAMETERS
//   CLK_DIV   2     sclk half-period in clk cycles (>=1); sclk = clk/(2*CLK_DIV)
//   CS_GAP    4     clk cycles cs is held high between commands (>=1)
//   POLL_MAX  24'hFFFFFF  max RDSR polls before error (used only with SPI_WRITER_TIMEOUT_EN)
// PORTS
//   clk     in   1   system clock
//   rst     in   1   synchronous reset, active-high
//   write   in   1   program request, sampled in IDLE only
//   erase   in   1   sector-erase request, sampled in IDLE only
//   addr    in   24  byte address (erase: device uses addr[23:12])
//   wdata   in   8   byte to program
//   busy    out  1   high from accept cycle+1 until the done pulse, inclusive
//   done    out  1   1-cycle pulse at end of transaction
//   error   out  1   timeout flag, valid with done (always 0 without the macro)
//   status  out  8   last RDSR byte read
//   sclk    out  1   SPI clock, mode 0, idle low
//   cs      out  1   chip select, active-low
//   mosi    out  1   serial out, MSB first
//   miso    in   1   serial in, sampled on sclk rising edge
// BEHAVIOUR
//   Reset values: busy=0, done=0, error=0, status=8'h00, sclk=0, cs=1, mosi=0.
//   Reset mid-operation: cs=1 and sclk=0 on the next edge. No done pulse. FSM returns to IDLE.
//   Accept: in IDLE, if (write|erase), latch addr, wdata and op. erase has priority when both are high.
//   Requests while busy are ignored. No queueing.
//   States: IDLE -> WREN -> GAP -> CMD -> GAP -> POLL -> (WIP ? GAP -> POLL : DONE) -> IDLE.
//   WREN: cs low, 8 bits 0x06, cs high.
//   CMD program: 40 bits {0x02, addr, wdata}.
//   CMD erase: 32 bits {0x20, addr}.
//   POLL: 8 bits 0x05 out, then 8 bits in. Shift into status MSB first. WIP = status[0].
//   Bit timing: mosi is set while sclk=0, CLK_DIV cycles before each rising edge. Each rising edge lasts CLK_DIV cycles.
//   cs falls CLK_DIV cycles before the first rising edge.
//   cs rises CLK_DIV cycles after the last falling edge. sclk ends low.
//   mosi=0 during the POLL read phase and while cs=1.
//   GAP: cs=1 for exactly CS_GAP clk cycles.
//   DONE: done=1 for one cycle with busy still 1. busy=0 on the next cycle.
//   A new request is accepted at the earliest in the cycle after done.
//   Bit counter and divider widths are sized for 40 bits and CLK_DIV. Divider wraps to 0 on each sclk toggle.
//   status updates only after a full 8-bit read completes. It holds across transactions and is cleared only by rst.
// CONFIGURATION
//   SPI_WRITER_TIMEOUT_EN defined:
//     - a 24-bit counter counts completed polls.
//     - if polls reach POLL_MAX with WIP still 1, go to DONE with error=1.
//     - error holds until the next accept or rst.
//   SPI_WRITER_TIMEOUT_EN undefined:
//     - no counter; polling is unbounded.
//     - error is tied to 0.
// TESTING
//   Flash model: decodes 0x06/0x02/0x20/0x05 and models WIP with a programmable busy time.
//   1. write=1, addr=24'h400000, wdata=8'hA5, CLK_DIV=2:
//      - mosi stream is 06 | gap | 02 40 00 00 A5 | gap | 05...
//      - model byte[0x400000]=A5; one done pulse; error=0.
//   2. erase=1, addr=24'h401234, model busy for 3 polls:
//      - exactly 4 RDSR transactions; status ends 8'h00.
//      - 4 KiB at 0x401000 reads FF; done once.
//   3. write and erase asserted together in IDLE: erase executes (0x20 seen, no 0x02).
//   4. write pulsed again while busy: ignored; exactly one WREN+PROG pair on the bus.
//   5. rst asserted during CMD bit 17:
//      - next cycle cs=1, sclk=0, busy=0; no done.
//      - a new write after reset completes normally.
//   6. With SPI_WRITER_TIMEOUT_EN, POLL_MAX=5, model stuck busy:
//      - 5 polls, then done=1 with error=1, status[0]=1.

Source files
------------

// File: rtl/spi_flash_writer.sv
// spi_flash_writer: SPI NOR flash program/erase engine (SPI mode 0).
// Each request runs WREN (0x06), then Page Program (0x02, one byte) or
// Sector Erase (0x20, 4 KiB), then polls RDSR (0x05) until WIP clears.
// Optional feature macro: SPI_WRITER_TIMEOUT_EN bounds polling to POLL_MAX
// polls and reports an expired bound on error.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   write, erase    request strobes, sampled in IDLE only (erase wins)
//   addr, wdata     byte address and program data, latched on accept
//   busy, done      busy from accept+1 through the one-cycle done pulse
//   error           poll timeout flag, valid with done
//   status          last complete RDSR byte
//   sclk, cs, mosi  SPI outputs (sclk idles low, cs active-low)
//   miso            SPI input, sampled on sclk rising edge
module spi_flash_writer #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CS_GAP   = 4,
    parameter logic [23:0] POLL_MAX = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write,
    input  logic        erase,
    input  logic [23:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  status,
    output logic        sclk,
    output logic        cs,
    output logic        mosi,
    input  logic        miso
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int unsigned BIT_W = $clog2(41);
    localparam int unsigned SR_W  = 40;

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_GAP, S_CMD, S_POLL, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d, nbits_q, nbits_d;
    logic [SR_W-2:0]   sr_q, sr_d;
    logic [6:0]        rx_q, rx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              gap_to_cmd_q, gap_to_cmd_d;
    logic              op_erase_q, op_erase_d;
    logic [23:0]       addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        status_q, status_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d;
    logic [SR_W-1:0]   frame;
    logic [BIT_W-1:0]  frame_bits;
    logic              xfer, tick, xfer_end, gap_end, start, poll_timeout;

    assign xfer     = (state_q == S_WREN) || (state_q == S_CMD) || (state_q == S_POLL);
    assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
    assign xfer_end = xfer && tick && !sclk_q && (bit_q == nbits_q);
    assign gap_end  = (state_q == S_GAP) && (gap_q == GAP_W'(CS_GAP - 1));
    assign start    = (state_d != state_q) &&
                      ((state_d == S_WREN) || (state_d == S_CMD) || (state_d == S_POLL));

    // Frame for the transfer being entered; trailing zeros keep mosi low
    // after the last command bit and through the RDSR read phase.
    always_comb begin
        frame      = {8'h05, 32'h0};
        frame_bits = BIT_W'(16);
        if (state_d == S_WREN) begin
            frame      = {8'h06, 32'h0};
            frame_bits = BIT_W'(8);
        end else if (state_d == S_CMD) begin
            frame      = op_erase_q ? {8'h20, addr_q, 8'h00} : {8'h02, addr_q, wdata_q};
            frame_bits = op_erase_q ? BIT_W'(32) : BIT_W'(40);
        end
    end

`ifdef SPI_WRITER_TIMEOUT_EN
    logic [23:0] polls_q, polls_d;
    logic        error_q, error_d;
    assign poll_timeout = (polls_q == POLL_MAX - 24'd1);
    assign error        = error_q;
`else
    logic unused_poll_max;
    assign unused_poll_max = ^POLL_MAX;
    assign poll_timeout    = 1'b0;
    assign error           = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (write || erase) state_d = S_WREN;
            S_WREN: if (xfer_end) state_d = S_GAP;
            S_CMD:  if (xfer_end) state_d = S_GAP;
            S_GAP:  if (gap_end) state_d = gap_to_cmd_q ? S_CMD : S_POLL;
            S_POLL: if (xfer_end) state_d = (status_q[0] && !poll_timeout) ? S_GAP : S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        div_d        = div_q;
        bit_d        = bit_q;
        nbits_d      = nbits_q;
        sr_d         = sr_q;
        rx_d         = rx_q;
        gap_d        = gap_q;
        gap_to_cmd_d = gap_to_cmd_q;
        op_erase_d   = op_erase_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        status_d     = status_q;
        sclk_d       = sclk_q;
        cs_d         = cs_q;
        mosi_d       = mosi_q;
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
`ifdef SPI_WRITER_TIMEOUT_EN
        polls_d      = polls_q;
        error_d      = error_q;
        if (state_q == S_IDLE && (write || erase)) begin
            polls_d = 24'd0;
            error_d = 1'b0;
        end
        if (state_q == S_POLL && xfer_end) begin
            polls_d = polls_q + 24'd1;
            if (status_q[0] && poll_timeout) error_d = 1'b1;
        end
`endif
        if (state_q == S_IDLE && (write || erase)) begin
            addr_d     = addr;
            wdata_d    = wdata;
            op_erase_d = erase;
        end

        // First bit is presented together with the cs fall.
        if (start) begin
            div_d   = '0;
            bit_d   = '0;
            nbits_d = frame_bits;
            sr_d    = frame[SR_W-2:0];
            mosi_d  = frame[SR_W-1];
            sclk_d  = 1'b0;
            cs_d    = 1'b0;
        end else if (xfer) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick && !sclk_q) begin
                if (bit_q == nbits_q) begin
                    cs_d   = 1'b1;
                    mosi_d = 1'b0;
                end else begin
                    sclk_d = 1'b1;
                    // RDSR read phase: bits 8..15 shift status in MSB first.
                    if (state_q == S_POLL && bit_q >= BIT_W'(8)) begin
                        if (bit_q == BIT_W'(15)) status_d = {rx_q, miso};
                        else                     rx_d     = {rx_q[5:0], miso};
                    end
                end
            end else if (tick) begin
                sclk_d = 1'b0;
                bit_d  = bit_q + BIT_W'(1);
                mosi_d = sr_q[SR_W-2];
                sr_d   = {sr_q[SR_W-3:0], 1'b0};
            end
        end

        if (state_q == S_GAP) gap_d = gap_end ? '0 : gap_q + GAP_W'(1);
        if (state_q != S_GAP) gap_to_cmd_d = (state_q == S_WREN);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            bit_q        <= '0;
            nbits_q      <= '0;
            sr_q         <= '0;
            rx_q         <= '0;
            gap_q        <= '0;
            gap_to_cmd_q <= 1'b0;
            op_erase_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            status_q     <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sclk_q       <= 1'b0;
            cs_q         <= 1'b1;
            mosi_q       <= 1'b0;
`ifdef SPI_WRITER_TIMEOUT_EN
            polls_q      <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            div_q        <= div_d;
            bit_q        <= bit_d;
            nbits_q      <= nbits_d;
            sr_q         <= sr_d;
            rx_q         <= rx_d;
            gap_q        <= gap_d;
            gap_to_cmd_q <= gap_to_cmd_d;
            op_erase_q   <= op_erase_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            status_q     <= status_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sclk_q       <= sclk_d;
            cs_q         <= cs_d;
            mosi_q       <= mosi_d;
`ifdef SPI_WRITER_TIMEOUT_EN
            polls_q      <= polls_d;
            error_q      <= error_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign status = status_q;
    assign sclk   = sclk_q;
    assign cs     = cs_q;
    assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_flash_writer.sv
// Bench for spi_flash_writer: behavioural SPI NOR model, scoreboard of
// expected done responses, and directed program/erase/reset scenarios.
module tb_spi_flash_writer;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned CS_GAP  = 4;

    logic        clk = 1'b0;
    logic        rst, write, erase, miso;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic        busy, done, error, sclk, cs, mosi;
    logic [7:0]  status;

    always #5 clk = ~clk;

    spi_flash_writer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .POLL_MAX(24'd5)) dut (
        .clk(clk), .rst(rst), .write(write), .erase(erase), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .error(error),
        .status(status), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- flash model ----------------
    logic [7:0] mem [int];
    logic [7:0] bytes [$];
    logic [7:0] last_cmd [$];
    logic [7:0] op_log [$];
    logic [7:0] shin, stat_sh;
    int  bitcnt = 0;
    int  rdsr_cnt = 0;
    int  wip_left = 0;
    int  busy_time = 0;
    bit  stuck = 1'b0;
    bit  wel = 1'b0;
    int  cyc = 0;
    int  t_csfall = 0, t_csrise = 0, t_lastfall = 0;
    bit  gap_valid = 1'b0;
    int  idle_viol = 0;

    function automatic logic [7:0] rd(input int a);
        return mem.exists(a) ? mem[a] : 8'hFF;
    endfunction

    function automatic int count_op(input int from, input logic [7:0] code);
        int n = 0;
        for (int i = from; i < op_log.size(); i++) if (op_log[i] == code) n++;
        return n;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge cs) begin
        if (gap_valid) check("cs_gap_cycles", cyc - t_csrise, CS_GAP);
        gap_valid = 1'b0;
        t_csfall  = cyc;
        bitcnt    = 0;
        bytes.delete();
        miso      = 1'b0;
    end

    always @(posedge sclk) if (cs === 1'b0) begin
        if (bitcnt == 0) check("cs_fall_to_first_rise", cyc - t_csfall, CLK_DIV);
        shin = {shin[6:0], mosi};
        bitcnt++;
        if (bitcnt % 8 == 0) begin
            bytes.push_back(shin);
            if (bitcnt == 8 && shin == 8'h05)
                stat_sh = {6'b0, wel, (stuck || wip_left > 0)};
        end
    end

    always @(negedge sclk) if (cs === 1'b0) begin
        t_lastfall = cyc;
        if (bitcnt >= 8 && bytes[0] == 8'h05) begin
            miso    = stat_sh[7];
            stat_sh = {stat_sh[6:0], 1'b0};
        end
    end

    always @(posedge cs) if (bytes.size() > 0) begin
        op_log.push_back(bytes[0]);
        if (rst !== 1'b1) begin
            check("last_fall_to_cs_rise", cyc - t_lastfall, CLK_DIV);
            gap_valid = 1'b1;
            t_csrise  = cyc;
        end
        case (bytes[0])
            8'h06: if (bitcnt == 8) wel = 1'b1;
            8'h02: if (bitcnt == 40 && wel) begin
                mem[int'({bytes[1], bytes[2], bytes[3]})] = bytes[4];
                last_cmd = bytes;
                wel = 1'b0;
                wip_left = busy_time;
            end
            8'h20: if (bitcnt == 32 && wel) begin
                for (int i = 0; i < 4096; i++)
                    mem.delete(int'({bytes[1], bytes[2][7:4], 12'h000}) + i);
                last_cmd = bytes;
                wel = 1'b0;
                wip_left = busy_time;
            end
            8'h05: if (bitcnt == 16) begin
                rdsr_cnt++;
                if (wip_left > 0) wip_left--;
            end
            default: ;
        endcase
    end

    // ---------------- scoreboard monitor ----------------
    typedef struct packed {
        logic       err;
        logic [7:0] st;
    } exp_t;

    exp_t sb [$];
    exp_t e;
    int   done_cnt = 0;
    bit   chk_next = 1'b0;

    always @(negedge clk) begin
        if (cs === 1'b1 && (mosi !== 1'b0 || sclk !== 1'b0)) idle_viol++;
        if (chk_next) begin
            check("busy_after_done", busy, 1'b0);
            chk_next = 1'b0;
        end
        if (rst === 1'b0 && done === 1'b1) begin
            done_cnt++;
            gap_valid = 1'b0;
            chk_next  = 1'b1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: got done pulse, expected none");
            end else begin
                e = sb.pop_front();
                check("error_at_done", error, e.err);
                check("status_at_done", status, e.st);
                check("busy_at_done", busy, 1'b1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input logic w, input logic er, input logic [23:0] a, input logic [7:0] d);
        @(negedge clk);
        write = w; erase = er; addr = a; wdata = d;
        @(negedge clk);
        write = 1'b0; erase = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start_cnt = done_cnt;
        int k = 0;
        while (done_cnt == start_cnt && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        check({name, "_done_count"}, done_cnt - start_cnt, 1);
        repeat (20) @(negedge clk);
    endtask

    int base_op, base_rd, nonff, dbefore, k;

    initial begin
        rst = 1'b1; write = 1'b0; erase = 1'b0; addr = '0; wdata = '0; miso = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_status", status, 8'h00);
        check("rst_sclk", sclk, 1'b0);
        check("rst_cs", cs, 1'b1);
        check("rst_mosi", mosi, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single-byte program, one busy poll
        base_op = op_log.size(); base_rd = rdsr_cnt; busy_time = 1;
        sb.push_back('{err: 1'b0, st: 8'h00});
        req(1'b1, 1'b0, 24'h400000, 8'hA5);
        wait_done("prog", 3000);
        check("prog_op0", op_log[base_op], 8'h06);
        check("prog_op1", op_log[base_op+1], 8'h02);
        check("prog_op2", op_log[base_op+2], 8'h05);
        check("prog_cmd_bytes", {last_cmd[1], last_cmd[2], last_cmd[3], last_cmd[4]}, 32'h400000A5);
        check("prog_mem", rd(24'h400000), 8'hA5);
        check("prog_rdsr", rdsr_cnt - base_rd, 2);

        // 2: sector erase, busy for three polls
        mem[24'h401000] = 8'h00; mem[24'h401FFF] = 8'h11; mem[24'h402000] = 8'h22;
        base_op = op_log.size(); base_rd = rdsr_cnt; busy_time = 3;
        sb.push_back('{err: 1'b0, st: 8'h00});
        req(1'b0, 1'b1, 24'h401234, 8'h00);
        wait_done("erase", 6000);
        check("erase_op1", op_log[base_op+1], 8'h20);
        check("erase_cmd_bytes", {last_cmd[0], last_cmd[1], last_cmd[2], last_cmd[3]}, 32'h20401234);
        check("erase_rdsr", rdsr_cnt - base_rd, 4);
        nonff = 0;
        for (int i = 0; i < 4096; i++) if (rd(24'h401000 + i) != 8'hFF) nonff++;
        check("erase_sector_ff", nonff, 0);
        check("erase_neighbour", rd(24'h402000), 8'h22);
        check("erase_other_kept", rd(24'h400000), 8'hA5);

        // 3: write and erase together, erase wins
        mem[24'h403010] = 8'h44;
        base_op = op_log.size(); busy_time = 0;
        sb.push_back('{err: 1'b0, st: 8'h00});
        req(1'b1, 1'b1, 24'h403000, 8'h5A);
        wait_done("both", 3000);
        check("both_erase_seen", count_op(base_op, 8'h20), 1);
        check("both_no_prog", count_op(base_op, 8'h02), 0);
        check("both_mem", rd(24'h403010), 8'hFF);

        // 4: request while busy is ignored
        base_op = op_log.size();
        sb.push_back('{err: 1'b0, st: 8'h00});
        req(1'b1, 1'b0, 24'h404000, 8'h3C);
        repeat (30) @(negedge clk);
        check("busy_mid_txn", busy, 1'b1);
        req(1'b1, 1'b0, 24'h405000, 8'h77);
        wait_done("ignore", 3000);
        repeat (200) @(negedge clk);
        check("ignore_wren_count", count_op(base_op, 8'h06), 1);
        check("ignore_prog_count", count_op(base_op, 8'h02), 1);
        check("ignore_mem_kept", rd(24'h404000), 8'h3C);
        check("ignore_mem_untouched", rd(24'h405000), 8'hFF);

        // 5: reset during the program command
        dbefore = done_cnt;
        req(1'b1, 1'b0, 24'h407000, 8'h99);
        k = 0;
        while (!(bytes.size() > 0 && bytes[0] == 8'h02 && bitcnt == 17) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check("abort_reached_bit17", bitcnt, 17);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs", cs, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("abort_no_done", done_cnt - dbefore, 0);
        check("abort_mem", rd(24'h407000), 8'hFF);
        sb.push_back('{err: 1'b0, st: 8'h00});
        req(1'b1, 1'b0, 24'h406000, 8'hC3);
        wait_done("after_rst", 3000);
        check("after_rst_mem", rd(24'h406000), 8'hC3);

`ifdef SPI_WRITER_TIMEOUT_EN
        // 6: stuck busy flash hits the poll limit
        base_rd = rdsr_cnt; stuck = 1'b1;
        sb.push_back('{err: 1'b1, st: 8'h01});
        req(1'b1, 1'b0, 24'h408000, 8'h11);
        wait_done("timeout", 6000);
        check("timeout_rdsr", rdsr_cnt - base_rd, 5);
        check("timeout_error_holds", error, 1'b1);
        stuck = 1'b0;
`endif

        check("scoreboard_empty", sb.size(), 0);
        check("idle_mosi_sclk_low", idle_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
